gb_apu_i2s_tx: RTL and testbench
================================

// Module: gb_apu_i2s_tx
// PURPOSE
//  Serialises the APU's 16-bit left/right mix into an I2S stereo stream for an external DAC.
//  Consumes the `left`/`right` outputs of gb_apu and sits between the APU top and the board pins.
//  Generates its own bit clock (BCLK) and word select (LRCK) from `clk`.
//  Both channels are latched together once per frame, so each frame carries a coherent stereo pair.
// PARAMETERS
//  CLK_DIV   2   clk cycles per BCLK half-period; must be >= 1. 4194304 Hz clk, CLK_DIV=2 -> 32768 Hz frame rate.
// PORTS
//  clk       in   1   system clock (APU clock domain)
//  reset_n   in   1   asynchronous, active-low reset
//  en_i      in   1   stream enable; when low, the block is held idle (same state as reset)
//  left_i    in   16  left sample, two's complement (from gb_apu.left)
//  right_i   in   16  right sample, two's complement (from gb_apu.right)
//  bclk_o    out  1   I2S bit clock, registered
//  lrck_o    out  1   word select: 0 = left half, 1 = right half, registered
//  sdata_o   out  1   serial data, MSB first, registered
//  frame_o   out  1   one-clk pulse when a new stereo pair is latched
// BEHAVIOUR
//  - Reset (or en_i=0): bclk_o=0, lrck_o=1, sdata_o=0, frame_o=0, div_cnt=0, bit_cnt=31, shift reg=0, latches=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and bclk_o toggles.
//    A 1->0 toggle is a "fall tick". All other state advances only on fall ticks.
//  - bit_cnt (5 bits): increments on every fall tick and wraps 31->0. A frame is 32 BCLK: 16 left, then 16 right.
//  - lrck_o <= (next bit_cnt >= 16). lrck_o therefore changes on the same fall tick where bit_cnt becomes 0 or 16.
//  - Fall tick with bit_cnt 31->0: lat_l <= left_i and lat_r <= right_i. frame_o is high for exactly that clk cycle.
//    Input changes at any other time do not affect the frame in flight.
//  - 32-bit shift reg sr; sdata_o is driven from sr[31]. On the load tick, sr <= {lat_l, lat_r}; otherwise sr <= sr << 1.
//    The load tick is defined under CONFIGURATION. Latches feed sr the tick after capture, so no bypass is needed.
//  - First frame after reset/enable: the first fall tick occurs 2*CLK_DIV clks after release and starts bit_cnt=0.
//    Bits ahead of the first sr load are 0.
//  - Frame period = 64*CLK_DIV clk cycles. Throughput is one stereo pair per frame.
//  - Reset or en_i falling mid-frame: immediate return to the reset state and the partial frame is abandoned.
//    On re-enable, streaming restarts with a fresh latch.
//  - No arithmetic on sample values. Bits are transmitted verbatim.
// CONFIGURATION
//  Macro GB_I2S_LEFT_JUSTIFIED_EN.
//  - Undefined (standard I2S):
//    - sr loads on the fall tick where bit_cnt goes 0->1, so the MSB lags the LRCK edge by one BCLK.
//    - Right-channel LSB goes out during bit_cnt=0 of the following frame.
//  - Defined (left-justified): sr loads on the 31->0 tick directly from left_i/right_i, bypassing the latches.
//    The MSB is coincident with the LRCK edge, and the LSB falls in bit_cnt 15 (left) / 31 (right).
// STRUCTURE
//  - gb_apu_pkg (shared):
//    - typedef logic signed [15:0] apu_sample_t
//    - localparam I2S_FRAME_BITS = 32
//    - localparam I2S_CHAN_BITS = 16
//  - Sub-module gb_i2s_clkdiv: div_cnt plus bclk register, param CLK_DIV, outputs bclk_o and fall_tick.
//  - The top holds bit_cnt, lrck, the latches, sr and frame_o.
// TESTING
//  1. CLK_DIV=2, reset release -> bclk_o period 4 clk; first bclk_o rise at clk 2; frame_o every 128 clk.
//  2. left_i=16'hA5F0, right_i=16'h0F0F, I2S mode -> sampling sdata_o on BCLK rises from bit_cnt=1 gives:
//     - left bits 1010_0101_1111_0000 (bit_cnt 1..16)
//     - right bits 0000_1111_0000_1111 (bit_cnt 17..31, then 0 of next frame)
//  3. Same stimulus with GB_I2S_LEFT_JUSTIFIED_EN -> 16'hA5F0 on bit_cnt 0..15 and 16'h0F0F on bit_cnt 16..31.
//  4. Change left_i 16'h7FFF->16'h8000 at bit_cnt=5 -> current frame still carries 7FFF; next frame carries 8000.
//  5. Assert reset_n=0 at bit_cnt=20 -> all outputs take reset values asynchronously; after release the first frame is well-formed.
//  6. en_i low for 10 clk mid-frame -> bclk_o held 0, lrck_o=1; on re-enable, identical timing to test 1.

Source files
------------

// File: rtl/gb_apu_pkg.sv
// Shared APU types and constants: sample type and I2S frame geometry.
package gb_apu_pkg;

   typedef logic signed [15:0] apu_sample_t;

   localparam int I2S_FRAME_BITS = 32;
   localparam int I2S_CHAN_BITS  = 16;

endpackage

// File: rtl/gb_i2s_clkdiv.sv
// I2S bit-clock generator: divides clk by 2*CLK_DIV into bclk_o and flags the
// clk cycle on which bclk_o is about to fall (fall_tick), which paces the serialiser.
// en_i low holds the divider in its reset state.
module gb_i2s_clkdiv #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   output logic bclk_o,
   output logic fall_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic          div_wrap;

   assign div_wrap  = (div_cnt == DIV_LAST);
   // A wrap while bclk is high is the 1->0 toggle everything else advances on.
   assign fall_tick = en_i & div_wrap & bclk_o;

   // Half-period counter; bclk toggles each time it wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         bclk_o  <= 1'b0;
      end else if (!en_i) begin
         div_cnt <= '0;
         bclk_o  <= 1'b0;
      end else if (div_wrap) begin
         div_cnt <= '0;
         bclk_o  <= ~bclk_o;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/gb_apu_i2s_tx.sv
// I2S stereo transmitter for the APU left/right mix.
// Both channels are latched together at the start of each 32-BCLK frame so every
// frame carries a coherent pair; data goes out MSB first on sdata_o.
// Build option: define GB_I2S_LEFT_JUSTIFIED_EN for left-justified framing
// (MSB coincident with the LRCK edge); default is standard I2S (one-BCLK delay).
module gb_apu_i2s_tx
   import gb_apu_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     en_i,
   input  logic [I2S_CHAN_BITS-1:0] left_i,
   input  logic [I2S_CHAN_BITS-1:0] right_i,
   output logic                     bclk_o,
   output logic                     lrck_o,
   output logic                     sdata_o,
   output logic                     frame_o
);

   localparam int BW = $clog2(I2S_FRAME_BITS);
   localparam logic [BW-1:0] BIT_LAST = BW'(I2S_FRAME_BITS - 1);

   logic                      fall_tick;
   logic [BW-1:0]             bit_cnt;
   logic [BW-1:0]             bit_nxt;
   logic                      frame_end;
   logic                      load_tick;
   logic [I2S_FRAME_BITS-1:0] load_word;
   logic [I2S_FRAME_BITS-1:0] sr;
   apu_sample_t               lat_l;
   apu_sample_t               lat_r;

   gb_i2s_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (en_i),
      .bclk_o    (bclk_o),
      .fall_tick (fall_tick)
   );

   assign bit_nxt   = bit_cnt + 1'b1;
   assign frame_end = (bit_cnt == BIT_LAST);

`ifdef GB_I2S_LEFT_JUSTIFIED_EN
   // Left-justified: load at the frame boundary straight from the inputs so the
   // MSB lines up with the LRCK edge.
   assign load_tick = fall_tick & frame_end;
   assign load_word = {left_i, right_i};
`else
   // Standard I2S: load one BCLK after the frame boundary from the latches,
   // which were captured on the previous tick.
   assign load_tick = fall_tick & (bit_cnt == '0);
   assign load_word = {lat_l, lat_r};
`endif

   assign sdata_o = sr[I2S_FRAME_BITS-1];

   // Frame position, word select, pair latches and frame pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= BIT_LAST;
         lrck_o  <= 1'b1;
         lat_l   <= '0;
         lat_r   <= '0;
         frame_o <= 1'b0;
      end else if (!en_i) begin
         bit_cnt <= BIT_LAST;
         lrck_o  <= 1'b1;
         lat_l   <= '0;
         lat_r   <= '0;
         frame_o <= 1'b0;
      end else begin
         frame_o <= fall_tick & frame_end;
         if (fall_tick) begin
            bit_cnt <= bit_nxt;
            // Right half is bit_cnt 16..31, i.e. the top bit of the 5-bit count.
            lrck_o  <= bit_nxt[BW-1];
            if (frame_end) begin
               lat_l <= apu_sample_t'(left_i);
               lat_r <= apu_sample_t'(right_i);
            end
         end
      end
   end

   // Output shift register: parallel load once per frame, else shift left per BCLK.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr <= '0;
      end else if (!en_i) begin
         sr <= '0;
      end else if (load_tick) begin
         sr <= load_word;
      end else if (fall_tick) begin
         sr <= {sr[I2S_FRAME_BITS-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_gb_apu_i2s_tx.sv
// Self-checking bench for gb_apu_i2s_tx. The reference model derives every output
// from the number of enabled clk edges since release plus the sample pairs present
// at each frame boundary, and follows the same GB_I2S_LEFT_JUSTIFIED_EN build option.
module tb_gb_apu_i2s_tx;

   localparam int CD = 2;

   logic        clk;
   logic        reset_n;
   logic        en_i;
   logic [15:0] left_i;
   logic [15:0] right_i;
   logic        bclk_o;
   logic        lrck_o;
   logic        sdata_o;
   logic        frame_o;

   int          n_checks;
   int          n_errors;
   int          n_edges;
   bit          rand_inputs;
   logic [31:0] exp_q[$];

   gb_apu_i2s_tx #(
      .CLK_DIV (CD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en_i),
      .left_i  (left_i),
      .right_i (right_i),
      .bclk_o  (bclk_o),
      .lrck_o  (lrck_o),
      .sdata_o (sdata_o),
      .frame_o (frame_o)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n_edges);
      end
   endtask

   // Model: number of fall ticks so far and the resulting bit position.
   function automatic int ticks();
      return n_edges / (2 * CD);
   endfunction

   function automatic int bit_pos();
      return (31 + ticks()) % 32;
   endfunction

   function automatic logic exp_sdata();
      int f;
      int b;
      int k;
      logic [31:0] w;
      f = ticks();
      if (f == 0) return 1'b0;
      b = bit_pos();
      k = (f - 1) / 32;
`ifdef GB_I2S_LEFT_JUSTIFIED_EN
      w = exp_q[k];
      return w[31-b];
`else
      if (b == 0) begin
         if (k == 0) return 1'b0;
         w = exp_q[k-1];
         return w[0];
      end
      w = exp_q[k];
      return w[32-b];
`endif
   endfunction

   task automatic check_outputs();
      int f;
      logic e_bclk;
      logic e_lrck;
      logic e_frame;
      f       = ticks();
      e_bclk  = ((n_edges / CD) % 2) == 1;
      e_lrck  = (f == 0) ? 1'b1 : (bit_pos() >= 16);
      e_frame = (f >= 1) && (n_edges % (2 * CD) == 0) && (((f - 1) % 32) == 0);
      check_eq("bclk",  {31'd0, bclk_o},  {31'd0, e_bclk});
      check_eq("lrck",  {31'd0, lrck_o},  {31'd0, e_lrck});
      check_eq("frame", {31'd0, frame_o}, {31'd0, e_frame});
      check_eq("sdata", {31'd0, sdata_o}, {31'd0, exp_sdata()});
   endtask

   // One clk: advance the model at the posedge, check at the negedge.
   task automatic step();
      int f;
      @(posedge clk);
      if (!reset_n || !en_i) begin
         n_edges = 0;
         exp_q.delete();
      end else begin
         n_edges++;
         f = ticks();
         if ((n_edges % (2 * CD) == 0) && (((f - 1) % 32) == 0))
            exp_q.push_back({left_i, right_i});
      end
      @(negedge clk);
      check_outputs();
      if (rand_inputs && $urandom_range(0, 7) == 0) begin
         left_i  = 16'($urandom);
         right_i = 16'($urandom);
      end
   endtask

   task automatic run_cycles(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic run_until_bit(input int b);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         step();
         if (ticks() >= 1 && bit_pos() == b) found = 1'b1;
      end
      check_eq("wait_bit", {31'd0, found}, 32'd1);
   endtask

   // stimulus
   initial begin
      n_checks    = 0;
      n_errors    = 0;
      n_edges     = 0;
      rand_inputs = 1'b0;
      reset_n     = 1'b0;
      en_i        = 1'b1;
      left_i      = 16'h0000;
      right_i     = 16'h0000;

      run_cycles(3);
      @(negedge clk);
      reset_n = 1'b1;

      // Fixed pattern, several frames.
      left_i  = 16'hA5F0;
      right_i = 16'h0F0F;
      run_cycles(3 * 64 * CD);

      // Random samples changing at arbitrary times.
      rand_inputs = 1'b1;
      run_cycles(5 * 64 * CD);
      rand_inputs = 1'b0;

      // Mid-frame change must not affect the frame in flight.
      left_i  = 16'h7FFF;
      right_i = 16'h1234;
      run_until_bit(0);
      run_until_bit(5);
      left_i = 16'h8000;
      run_cycles(2 * 64 * CD);

      // Asynchronous reset mid-frame.
      run_until_bit(20);
      #2;
      reset_n = 1'b0;
      #1;
      n_edges = 0;
      exp_q.delete();
      check_outputs();
      run_cycles(4);
      @(negedge clk);
      reset_n = 1'b1;
      left_i  = 16'h8001;
      right_i = 16'h7FFE;
      run_cycles(2 * 64 * CD + 8);

      // Enable dropped for 10 clk mid-frame.
      run_until_bit(10);
      en_i = 1'b0;
      run_cycles(10);
      en_i = 1'b1;
      rand_inputs = 1'b1;
      run_cycles(3 * 64 * CD);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
